pmem_line_responder: RTL and testbench
======================================

Name: pmem_line_responder

Overview:
- Responder end of the cache-line physical-memory interface. It services one 256-bit line read or write per transaction from a line cache's pmem_* initiator port.
- It is backed by an internal line array, with a fixed, parameterised response latency.
- It is used as the synthesizable main-memory stand-in below the instruction/data caches, and as the reference responder in cache benches.

Parameters:
- s_offset, 5, byte-offset bits per line; pmem_addr[s_offset-1:0] is ignored.
- s_line, 256, line width in bits (8 * 2**s_offset).
- s_depth, 6, log2 of lines stored; the backing array is 2**s_depth lines.
- latency, 4, cycles from request acceptance to pmem_resp; must be >=1 (elaboration error otherwise).

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  synchronous active-low reset.
- pmem_read  in  1  line read request; held high until pmem_resp is seen.
- pmem_write  in  1  line write request; held high until pmem_resp is seen.
- pmem_addr  in  32  line address; low s_offset bits ignored.
- pmem_wdata  in  s_line  write line data.
- pmem_rdata  out  s_line  read line data; valid only in the pmem_resp cycle.
- pmem_resp  out  1  one-cycle completion pulse.
- pmem_error  out  1  qualifies pmem_resp; request failed.

Behaviour:
- Reset (rst_n low at posedge):
  - State goes to IDLE; pmem_resp=0, pmem_error=0, pmem_rdata=0; latency counter cleared.
  - Array contents are NOT reset.
- States:
  - IDLE: accepts when (pmem_read|pmem_write)=1 at posedge. Captures pmem_addr[31:s_offset], pmem_wdata, read/write flags; goes to WAIT (or directly to RESP if latency==1).
  - WAIT: counts down; reaches RESP so that pmem_resp is high exactly in cycle t0+latency, where t0 is the accept cycle.
  - RESP: pmem_resp=1 for exactly one cycle; next state is RECOVER.
  - RECOVER: one cycle, requests ignored (the initiator drops its request registers the cycle after resp); then IDLE.
- Request inputs are don't-care outside IDLE; captured values are used, so later changes to addr/wdata have no effect.
- Write:
  - Array line [captured index] is updated with the captured wdata at the posedge ending the RESP cycle.
  - pmem_rdata is unchanged by a write.
- Read:
  - pmem_rdata is driven with the array line in the RESP cycle, registered so it is stable for the whole cycle. It holds that value afterward until the next read response.
  - A read accepted after a write to the same line returns the new data (back-to-back minimum spacing is RESP→RECOVER→IDLE accept).
- Error, with pmem_resp=1 and pmem_error=1:
  - Captured addr[31:s_offset+s_depth] is nonzero (out of range): read returns all zeros; write is dropped.
  - pmem_read and pmem_write are both high at accept: treated as error, no array update, rdata=0.
- pmem_error=0 in every cycle where pmem_resp=0.
- Reset asserted mid-transaction (WAIT/RESP): the transaction is abandoned, no resp is issued, a pending write is discarded, array is unchanged.
- Throughput: one transaction per latency+2 cycles maximum.
- Index = addr[s_offset+s_depth-1:s_offset], with no wrap-around within range; out-of-range addresses error rather than alias.

Test Plan:
- Reset, then write 0xA5A5…A5 (256b) to addr 0x00000040 with latency=4 → pmem_resp high exactly in cycle t0+4 for one cycle, error=0. Then read 0x0000005F → rdata=0xA5A5…A5 in the resp cycle.
- Read, then write, then read the same line with differing data; initiator drops the request the cycle after resp and re-raises it in the RECOVER cycle → the RECOVER-cycle request is ignored and accepted the next cycle; final read returns the latest data.
- Read of 0x00010000 (beyond 64 lines) → resp with error=1, rdata=0. Write to the same address → error=1, and line index 0 is unchanged on a subsequent read of 0x00000000.
- pmem_read and pmem_write both high → resp+error after latency cycles; no array change.
- Assert rst_n=0 two cycles after accepting a write of 0xFFFF…FF to 0x20 → no pmem_resp. Read of 0x20 after reset returns prior contents.
- latency=1 build: request at cycle 0 → resp in cycle 1. Sustained requests complete every 3 cycles.

Source files
------------

// File: rtl/pmem_line_responder.sv
// Cache-line memory responder: one 256-bit line read/write per transaction, fixed latency.
// Resp pulses exactly `latency` cycles after accept, then one recover cycle in which requests are ignored.
module pmem_line_responder #(
   parameter int s_offset = 5,
   parameter int s_line   = 256,
   parameter int s_depth  = 6,
   parameter int latency  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pmem_read,
   input  logic              pmem_write,
   input  logic [31:0]       pmem_addr,
   input  logic [s_line-1:0] pmem_wdata,
   output logic [s_line-1:0] pmem_rdata,
   output logic              pmem_resp,
   output logic              pmem_error
);

   localparam int cnt_w = (latency > 1) ? $clog2(latency) : 1;

   generate
      if (latency < 1) begin : g_bad_latency
         $error("pmem_line_responder: latency must be >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      RESP    = 2'd2,
      RECOVER = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [cnt_w-1:0]   cnt_q;
   logic [s_depth-1:0] idx_q;
   logic               rd_q;
   logic               wr_q;
   logic               err_q;
   logic [s_line-1:0]  wdata_q;
   logic [s_line-1:0]  rdata_q;

   logic [s_line-1:0]  mem [2**s_depth];

   logic               accept;
   logic               enter_resp;
   logic [s_depth-1:0] req_idx;
   logic               req_err;
   logic               rsp_rd;
   logic               rsp_err;
   logic [s_depth-1:0] rsp_idx;
   logic               mem_we;

   // Byte-offset bits select within a line and play no part in addressing.
   logic unused_offset_bits;
   assign unused_offset_bits = ^pmem_addr[s_offset-1:0];

   assign req_idx = pmem_addr[s_offset+s_depth-1:s_offset];
   assign req_err = (|pmem_addr[31:s_offset+s_depth]) | (pmem_read & pmem_write);

   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      case (state_q)
         IDLE: begin
            if (pmem_read | pmem_write) begin
               accept  = 1'b1;
               state_d = (latency == 1) ? RESP : WAIT;
            end
         end
         WAIT:    if (cnt_q == cnt_w'(1)) state_d = RESP;
         RESP:    state_d = RECOVER;
         RECOVER: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      enter_resp = (state_q != RESP) && (state_d == RESP);

      // With latency 1 the response is set up from the live request in the accept cycle.
      rsp_rd  = (state_q == IDLE) ? pmem_read : rd_q;
      rsp_err = (state_q == IDLE) ? req_err   : err_q;
      rsp_idx = (state_q == IDLE) ? req_idx   : idx_q;

      pmem_resp  = (state_q == RESP);
      pmem_error = (state_q == RESP) && err_q;
      pmem_rdata = rdata_q;
      mem_we     = rst_n && (state_q == RESP) && wr_q && !err_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cnt_q   <= cnt_w'(latency - 1);
            idx_q   <= req_idx;
            rd_q    <= pmem_read;
            wr_q    <= pmem_write;
            err_q   <= req_err;
            wdata_q <= pmem_wdata;
         end else if (state_q == WAIT) begin
            cnt_q <= cnt_q - cnt_w'(1);
         end
         if (enter_resp && rsp_rd) begin
            rdata_q <= rsp_err ? '0 : mem[rsp_idx];
         end
      end
   end

   // Backing array is deliberately not reset; the write lands as RESP ends.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[idx_q] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_pmem_line_responder.sv
// Scoreboarded bench for pmem_line_responder: directed protocol cases plus random traffic (latency 4), and a latency-1 pacing check.
module tb_pmem_line_responder;

   localparam int LAT = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         pmem_read, pmem_write;
   logic [31:0]  pmem_addr;
   logic [255:0] pmem_wdata, pmem_rdata;
   logic         pmem_resp, pmem_error;

   logic         r1, w1;
   logic [31:0]  a1;
   logic [255:0] wd1, rd1;
   logic         resp1, err1;

   always #5 clk = ~clk;

   pmem_line_responder #(.latency(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
      .pmem_resp(pmem_resp), .pmem_error(pmem_error)
   );

   pmem_line_responder #(.latency(1)) dut_l1 (
      .clk(clk), .rst_n(rst_n), .pmem_read(r1), .pmem_write(w1),
      .pmem_addr(a1), .pmem_wdata(wd1), .pmem_rdata(rd1),
      .pmem_resp(resp1), .pmem_error(err1)
   );

   typedef struct {
      int           cyc;
      bit           err;
      logic [255:0] data;
   } exp_t;

   exp_t         q[$];
   exp_t         mon_e;
   logic [255:0] mem_m [64];
   logic [255:0] last_rd;
   int           ready;
   int           cyc = 0;
   int           tests = 0;
   int           fails = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp_v);
      tests++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp_v);
      end
   endtask

   function automatic logic [255:0] rand_line();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Monitor: every response is matched against the oldest expectation.
   always @(negedge clk) begin
      if (pmem_resp) begin
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_resp @cycle %0d", cyc);
         end else begin
            mon_e = q.pop_front();
            check("resp_cycle", 256'(cyc), 256'(mon_e.cyc));
            check("resp_error", 256'(pmem_error), 256'(mon_e.err));
            check("resp_rdata", pmem_rdata, mon_e.data);
         end
      end else begin
         check("error_without_resp", 256'(pmem_error), 256'(0));
      end
   end

   // Reference: accept at the later of request-raise and ready cycle; resp LAT later; ready again 2 after resp.
   task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr, input logic [255:0] wd);
      exp_t e;
      int   t0;
      int   idx;
      bit   err;
      bit   done;
      @(negedge clk);
      pmem_read  = rd;
      pmem_write = wr;
      pmem_addr  = addr;
      pmem_wdata = wd;
      t0    = (cyc > ready) ? cyc : ready;
      idx   = int'(addr[10:5]);
      err   = (addr[31:11] != 0) || (rd && wr);
      e.cyc = t0 + LAT;
      e.err = err;
      if (rd) begin
         e.data  = err ? 256'd0 : mem_m[idx];
         last_rd = e.data;
      end else begin
         e.data = last_rd;
      end
      if (wr && !err) mem_m[idx] = wd;
      q.push_back(e);
      ready = t0 + LAT + 2;
      done  = 1'b0;
      for (int i = 0; i < LAT + 12 && !done; i++) begin
         @(negedge clk);
         if (pmem_resp) done = 1'b1;
      end
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      pmem_addr  = $urandom;
      pmem_wdata = rand_line();
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL txn_timeout addr %h: got no resp, expected resp at cycle %0d", addr, e.cyc);
         q.delete();
      end
   endtask

   initial begin
      logic [255:0] a5;
      logic [255:0] ones;
      logic [255:0] d;
      logic [31:0]  addr;
      int           mode;
      int           c;

      a5         = {32{8'hA5}};
      ones       = '1;
      last_rd    = '0;
      rst_n      = 1'b0;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      pmem_addr  = '0;
      pmem_wdata = '0;
      r1 = 1'b0; w1 = 1'b0; a1 = '0; wd1 = '0;

      repeat (3) @(negedge clk);
      check("reset_resp",  256'(pmem_resp),  256'(0));
      check("reset_error", 256'(pmem_error), 256'(0));
      check("reset_rdata", pmem_rdata, 256'd0);
      rst_n = 1'b1;
      ready = cyc;

      for (int i = 0; i < 64; i++) do_txn(1'b0, 1'b1, 32'(i << 5), rand_line());

      do_txn(1'b0, 1'b1, 32'h40, a5);
      do_txn(1'b1, 1'b0, 32'h5F, '0);

      // Back-to-back: each new request is raised in the RECOVER cycle of the previous one.
      do_txn(1'b1, 1'b0, 32'h80, '0);
      do_txn(1'b0, 1'b1, 32'h80, rand_line());
      do_txn(1'b1, 1'b0, 32'h80, '0);
      do_txn(1'b0, 1'b1, 32'h9C, rand_line());
      do_txn(1'b1, 1'b0, 32'h84, '0);

      do_txn(1'b1, 1'b0, 32'h0001_0000, '0);
      do_txn(1'b0, 1'b1, 32'h0001_0000, rand_line());
      do_txn(1'b1, 1'b0, 32'h0000_0000, '0);

      do_txn(1'b1, 1'b1, 32'h60, rand_line());
      do_txn(1'b1, 1'b0, 32'h60, '0);

      // Reset two cycles into a write: no resp, array untouched, rdata cleared.
      @(negedge clk);
      while (cyc < ready) @(negedge clk);
      pmem_write = 1'b1;
      pmem_addr  = 32'h20;
      pmem_wdata = ones;
      repeat (2) @(negedge clk);
      rst_n      = 1'b0;
      pmem_write = 1'b0;
      repeat (2) @(negedge clk);
      check("midreset_resp",  256'(pmem_resp), 256'(0));
      check("midreset_rdata", pmem_rdata, 256'd0);
      last_rd = '0;
      rst_n   = 1'b1;
      ready   = cyc;
      repeat (LAT + 2) @(negedge clk);
      do_txn(1'b1, 1'b0, 32'h20, '0);

      for (int n = 0; n < 250; n++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         addr = ($urandom_range(0, 63) << 5) | $urandom_range(0, 31);
         if ($urandom_range(0, 7) == 0) addr = addr | (32'h800 << $urandom_range(0, 20));
         mode = $urandom_range(0, 9);
         d    = rand_line();
         if (mode == 0)      do_txn(1'b1, 1'b1, addr, d);
         else if (mode < 5)  do_txn(1'b0, 1'b1, addr, d);
         else                do_txn(1'b1, 1'b0, addr, d);
      end

      // Latency-1 instance: write then sustained reads complete every 3 cycles.
      d = rand_line();
      @(negedge clk);
      w1  = 1'b1;
      a1  = 32'h60;
      wd1 = d;
      c   = cyc;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         check("l1_resp_pacing", 256'(resp1), 256'((k % 3) == 1));
         check("l1_error",       256'(err1),  256'(0));
         if (k > 1 && (k % 3) == 1) check("l1_rdata", rd1, d);
         if (k == 1)  w1 = 1'b0;
         if (k == 2)  r1 = 1'b1;
         if (k == 12) r1 = 1'b0;
      end
      check("l1_elapsed", 256'(cyc - c), 256'(12));

      repeat (LAT + 4) @(negedge clk);
      check("queue_drained", 256'(q.size()), 256'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
